// File: rtl/cache_ctrl_2way.sv
// Sequencing controller for a 2-way set-associative byte cache (2 lines x 2 ways x 8 bytes).
// Holds tags/valid/LRU, decides hit or miss, and refills whole blocks from byte-wide memory.
module cache_ctrl_2way #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ready,
  output logic [7:0]            cpu_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic                  cache_rdline,
  output logic [2:0]            cache_rdoffset,
  output logic                  cache_rdentry,
  output logic                  cache_wrline,
  output logic [2:0]            cache_wroffset,
  output logic                  cache_wrentry,
  output logic                  cache_wren,
  output logic [7:0]            cache_data,
  input  logic [7:0]            cache_q,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);
  localparam int TW = ADDR_WIDTH - 4;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    way_q, way_d;
  logic [2:0]              fill_q, fill_d;
  logic [1:0][1:0]         valid_q, valid_d;
  logic [1:0][1:0][TW-1:0] tag_q, tag_d;
  logic [1:0]              lru_q, lru_d;
  logic [15:0]             hit_cnt_q, hit_cnt_d;
  logic [15:0]             miss_cnt_q, miss_cnt_d;

  logic [TW-1:0] tag_r;
  logic          line_r;
  logic [2:0]    off_r;
  logic [1:0]    hit_w;
  logic          victim;

  assign tag_r  = addr_q[ADDR_WIDTH-1:4];
  assign line_r = addr_q[3];
  assign off_r  = addr_q[2:0];

  always_comb begin
    for (int unsigned w = 0; w < 2; w++) begin
      hit_w[w] = valid_q[line_r][w] && (tag_q[line_r][w] == tag_r);
    end
  end

  // First invalid way wins (way 0 before way 1); otherwise the LRU way.
  assign victim = !valid_q[line_r][0] ? 1'b0 :
                  !valid_q[line_r][1] ? 1'b1 : lru_q[line_r];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    way_d      = way_q;
    fill_d     = fill_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|hit_w) begin
          way_d     = ~hit_w[0];
          hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
          state_d   = S_RESP;
        end else begin
          way_d                   = victim;
          fill_d                  = '0;
          valid_d[line_r][victim] = 1'b0;
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7) begin
            tag_d[line_r][way_q]   = tag_r;
            valid_d[line_r][way_q] = 1'b1;
            state_d                = S_RESP;
          end
        end
      end
      S_RESP: begin
        lru_d[line_r] = ~way_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      way_q      <= 1'b0;
      fill_q     <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      way_q      <= way_d;
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign cpu_ready      = (state_q == S_RESP);
  assign cpu_data       = cache_q;
  assign mem_rd         = (state_q == S_FILL);
  assign mem_addr       = {tag_r, line_r, fill_q};
  assign cache_rdline   = line_r;
  assign cache_rdoffset = off_r;
  assign cache_rdentry  = way_q;
  assign cache_wren     = (state_q == S_FILL) && mem_ack;
  assign cache_wrline   = line_r;
  assign cache_wroffset = fill_q;
  assign cache_wrentry  = way_q;
  assign cache_data     = mem_data;
  assign hit_count      = hit_cnt_q;
  assign miss_count     = miss_cnt_q;
endmodule
